// File: rtl/pattern_sequencer_pkg.sv
// Shared constants for the pattern sequencer: step-mode encodings and the
// length of the optional input glitch filter.
package patseq_pkg;

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_FREE  = 2'b01;
  localparam logic [1:0] MODE_EDGE  = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  localparam int FILT_LEN = 4;

endpackage

// File: rtl/pattern_sequencer_if.sv
// Control/status bundle of the pattern sequencer: event input, mode, direction,
// pattern table in; registered pattern, index and tick out.
interface pattern_sequencer_if #(
  parameter int OUT_W = 8,
  parameter int N_PAT = 7
);
  localparam int IW = $clog2(N_PAT);

  logic                     in;
  logic [1:0]               mode;
  logic                     dir;
  logic [N_PAT*OUT_W-1:0]   pat_tbl;
  logic [OUT_W-1:0]         out;
  logic [IW-1:0]            idx;
  logic                     tick;

  modport master (
    output in, mode, dir, pat_tbl,
    input  out, idx, tick
  );

  modport slave (
    input  in, mode, dir, pat_tbl,
    output out, idx, tick
  );
endinterface

// File: rtl/pattern_sequencer_tick_gen.sv
// Clock-enable divider: counts 0..DIV-1 and raises tick for the single cycle
// in which the count sits at DIV-1.
module tick_gen #(
  parameter int DIV = 3000002
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);
endmodule

// File: rtl/pattern_sequencer.sv
// Tick-driven pattern sequencer with synchronised active-low event input.
// Optional PATSEQ_GLITCH_FILTER_EN adds a FILT_LEN-cycle input debounce.
module pattern_sequencer
  import patseq_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int N_PAT = 7,
  parameter int DIV   = 3000002
) (
  input  logic                clk,
  input  logic                rst,
  pattern_sequencer_if.slave  bus
);
  localparam int IW    = $clog2(N_PAT);
  localparam int TBL_D = 2 ** IW;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_PAT - 1);

  logic             w_tick;
  logic             r_sync1, r_sync2, r_ins_d, r_pend;
  logic             w_in_s, w_fall, w_step, w_pend_next;
  logic [IW-1:0]    r_idx, w_idx_next;
  logic [OUT_W-1:0] r_out;
  logic [OUT_W-1:0] w_tbl [TBL_D];

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // Pad the table to a power of two so an out-of-range index reads zero.
  for (genvar gi = 0; gi < TBL_D; gi++) begin : g_tbl
    if (gi < N_PAT) begin : g_used
      assign w_tbl[gi] = bus.pat_tbl[gi*OUT_W +: OUT_W];
    end else begin : g_pad
      assign w_tbl[gi] = '0;
    end
  end

`ifdef PATSEQ_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILT_LEN);
  logic           r_filt;
  logic [FCW-1:0] r_filt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt     <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_sync2 == r_filt) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FCW'(FILT_LEN - 1)) begin
      r_filt     <= r_sync2;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign w_in_s = r_filt;
`else
  assign w_in_s = r_sync2;
`endif

  always_comb begin
    w_fall      = r_ins_d & ~w_in_s;
    w_step      = 1'b0;
    w_pend_next = 1'b0;
    w_idx_next  = r_idx;
    if (w_tick) begin
      case (bus.mode)
        MODE_LEVEL: w_step = ~w_in_s;
        MODE_FREE:  w_step = 1'b1;
        MODE_EDGE:  w_step = r_pend;
        default:    w_step = 1'b0;
      endcase
    end
    // An edge seen in the tick cycle survives the clear and counts next tick.
    if (bus.mode == MODE_EDGE) begin
      w_pend_next = w_tick ? w_fall : (r_pend | w_fall);
    end
    if (r_idx > LAST_IDX) begin
      w_idx_next = '0;
    end else if (w_step) begin
      if (bus.dir) begin
        w_idx_next = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end else begin
        w_idx_next = (r_idx == '0) ? LAST_IDX : r_idx - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_ins_d <= 1'b1;
      r_pend  <= 1'b0;
      r_idx   <= '0;
      r_out   <= '0;
    end else begin
      r_sync1 <= bus.in;
      r_sync2 <= r_sync1;
      r_ins_d <= w_in_s;
      r_pend  <= w_pend_next;
      r_idx   <= w_idx_next;
      r_out   <= w_tbl[r_idx];
    end
  end

  assign bus.out  = r_out;
  assign bus.idx  = r_idx;
  assign bus.tick = w_tick;
endmodule
